// File: rtl/square_if.sv
`default_nettype none
// ============================================================================
//  Module      : square_if
//  Description : Start/finish handshake bundle for the sequential squarer.
//                master drives the operand and start request; slave returns
//                the registered square and the done/busy status.
//  Signals     : init   - start request (pulse or level)
//                A      - unsigned operand, WIDTH bits
//                result - unsigned A*A, 2*WIDTH bits
//                done   - operation complete, result valid
//                busy   - iteration in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface square_if #(
    parameter int WIDTH = 16
);
    logic                 init;
    logic [WIDTH-1:0]     A;
    logic [2*WIDTH-1:0]   result;
    logic                 done;
    logic                 busy;

    modport master (
        output init,
        output A,
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  init,
        input  A,
        output result,
        output done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/square.sv
`default_nettype none
// ============================================================================
//  Module      : square
//  Description : Sequential shift-and-add squarer. Captures A on the start
//                edge and accumulates one partial product per clock over
//                WIDTH iterations, then presents A*A on result and raises
//                done until init is released.
//  Ports       : clk - system clock, rising edge
//                rst - synchronous active-high reset
//                bus - square_if.slave (init, A in; result, done, busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
module square #(
    parameter int WIDTH = 16
) (
    input  wire        clk,
    input  wire        rst,
    square_if.slave    bus
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplr;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2*WIDTH-1:0]     r_result;

    state_t                 w_state_nxt;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic [2*WIDTH-1:0]     w_mcand_nxt;
    logic [WIDTH-1:0]       w_mplr_nxt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [2*WIDTH-1:0]     w_result_nxt;
    logic [2*WIDTH-1:0]     w_acc_sum;

    // Partial product for this iteration: add the shifted multiplicand only
    // when the current multiplier LSB is set.
    assign w_acc_sum = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplr   <= w_mplr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplr_nxt   = r_mplr;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;

        case (r_state)
            IDLE: begin
                if (bus.init) begin
                    w_mcand_nxt = {{WIDTH{1'b0}}, bus.A};
                    w_mplr_nxt  = bus.A;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = c_cnt_w'(WIDTH);
                    w_state_nxt = ITER;
                end
            end
            ITER: begin
                w_acc_nxt   = w_acc_sum;
                w_mcand_nxt = r_mcand << 1;
                w_mplr_nxt  = r_mplr >> 1;
                w_cnt_nxt   = r_cnt - c_cnt_w'(1);
                // Last iteration: publish the sum including this edge's add.
                if (r_cnt == c_cnt_w'(1)) begin
                    w_result_nxt = w_acc_sum;
                    w_state_nxt  = DONE;
                end
            end
            DONE: begin
                // A held init must not retrigger; wait for it to drop.
                if (!bus.init) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.result = r_result;
    assign bus.done   = (r_state == DONE);
    assign bus.busy   = (r_state == ITER);

endmodule
`default_nettype wire

// File: tb/tb_square.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square
//  Description : Self-checking bench for square. Directed corner operands
//                plus randomized operations compared against A*A and the
//                expected start/busy/done timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_square;

    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    logic [2*WIDTH-1:0] prev_result;

    square_if #(.WIDTH(WIDTH)) bus ();

    square #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation. hold keeps init high throughout; disturb scrambles
    // A and init during iteration.
    task automatic run_op(input logic [WIDTH-1:0] a, input bit hold, input bit disturb);
        logic [2*WIDTH-1:0] exp_sq;
        exp_sq = 32'(a) * 32'(a);
        bus.A    = a;
        bus.init = 1'b1;
        tick();                                  // start edge
        if (!hold) bus.init = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check("busy_iter", 64'(bus.busy), 64'd1);
            check("done_iter", 64'(bus.done), 64'd0);
            check("result_held", 64'(bus.result), 64'(prev_result));
            if (disturb) begin
                bus.A    = WIDTH'($urandom);
                bus.init = 1'($urandom);
            end
            tick();
        end
        check("done_set", 64'(bus.done), 64'd1);
        check("busy_clr", 64'(bus.busy), 64'd0);
        check("result", 64'(bus.result), 64'(exp_sq));
        prev_result = exp_sq;
        if (hold) begin
            bus.init = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("done_hold", 64'(bus.done), 64'd1);
                check("busy_hold", 64'(bus.busy), 64'd0);
            end
        end
        bus.init = 1'b0;
        tick();
        check("done_drop", 64'(bus.done), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("result_kept", 64'(bus.result), 64'(exp_sq));
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        prev_result = '0;
        rst      = 1'b1;
        bus.init = 1'b0;
        bus.A    = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_busy", 64'(bus.busy), 64'd0);
            check("idle_done", 64'(bus.done), 64'd0);
        end

        run_op(16'd255, 1'b0, 1'b0);
        run_op(16'hFFFF, 1'b1, 1'b0);
        run_op(16'd0, 1'b0, 1'b0);
        run_op(16'd1, 1'b0, 1'b0);
        run_op(16'h8000, 1'b0, 1'b0);
        run_op(16'd1000, 1'b0, 1'b1);
        run_op(16'd7, 1'b0, 1'b0);

        // Reset partway through an operation aborts it.
        bus.A    = 16'd300;
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        prev_result = '0;
        tick();
        check("abort_no_done", 64'(bus.done), 64'd0);
        run_op(16'd300, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_op(WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
